fix_multi_session_controller: RTL and testbench



---
 rtl/fix_session_pkg.sv | 37 +++
 rtl/fix_rr_arbiter.sv | 48 ++++
 rtl/fix_multi_session_controller.sv | 219 +++++++++++++++++++++
 tb/tb_fix_multi_session_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_session_pkg.sv
// Shared message-type codes, per-session state encoding and inbound message record
// for the multi-session FIX controller.
package fix_session_pkg;

  localparam logic [2:0] MSG_LOGON     = 3'b001;
  localparam logic [2:0] MSG_HEARTBEAT = 3'b010;
  localparam logic [2:0] MSG_TESTREQ   = 3'b011;
  localparam logic [2:0] MSG_LOGOUT    = 3'b100;
  localparam logic [2:0] MSG_BUSINESS  = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CONFIGURED,
    S_CONNECTING,
    S_TX,
    S_LOGON_WAIT,
    S_ACTIVE,
    S_TESTREQ_WAIT,
    S_LOGOUT_WAIT,
    S_DISCONNECT
  } sess_state_e;

  typedef struct packed {
    logic [2:0] msg_type;
    logic       seq_ok;
  } rx_msg_t;

  // States that exist only while the transport is expected to be up.
  function automatic logic is_linked(sess_state_e s);
    return s inside {S_TX, S_LOGON_WAIT, S_ACTIVE, S_TESTREQ_WAIT, S_LOGOUT_WAIT};
  endfunction

  function automatic logic is_wait(sess_state_e s);
    return s inside {S_LOGON_WAIT, S_TESTREQ_WAIT, S_LOGOUT_WAIT};
  endfunction

endpackage

// File: rtl/fix_rr_arbiter.sv
// Round-robin grant over N requesters; grant is combinational from the pointer, the
// pointer moves past the launched requester when that request is acknowledged.
module fix_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         launch_i,
  input  logic         ack_i,
  output logic [N-1:0] gnt_o
);

  logic [IW-1:0] ptr_q, ptr_d, last_q, last_d, sel;
  logic [IW:0]   cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req_i[cand[IW-1:0]]) begin
        found = 1'b1;
        sel   = cand[IW-1:0];
      end
    end
    if (found) gnt_o[sel] = 1'b1;
    last_d = launch_i ? sel : last_q;
    ptr_d  = ptr_q;
    if (ack_i) ptr_d = (last_q == IW'(N-1)) ? '0 : last_q + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      last_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fix_multi_session_controller.sv
// N independent FIX session FSMs with per-session timers and sequence numbers, sharing one
// registered build request (held until ack, one idle cycle between grants).
module fix_multi_session_controller
  import fix_session_pkg::*;
#(
  parameter int NUM_SESSIONS = 4,
  parameter int SEQ_W        = 16,
  parameter int HB_INTERVAL  = 1000,
  parameter int RX_GRACE     = 500,
  parameter int RESP_TIMEOUT = 2000,
  parameter int SID_W        = $clog2(NUM_SESSIONS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SESSIONS-1:0] configure_i,
  input  logic [NUM_SESSIONS-1:0] start_i,
  input  logic [NUM_SESSIONS-1:0] end_session_i,
  input  logic [NUM_SESSIONS-1:0] send_app_i,
  input  logic [NUM_SESSIONS-1:0] connected_i,
  input  logic                    rx_valid_i,
  input  logic [SID_W-1:0]        rx_session_i,
  input  logic [2:0]              rx_msg_type_i,
  input  logic                    rx_seq_ok_i,
  input  logic                    msg_ack_i,
  output logic                    msg_req_o,
  output logic [SID_W-1:0]        msg_session_o,
  output logic [2:0]              msg_type_o,
  output logic [SEQ_W-1:0]        msg_seq_o,
  output logic [NUM_SESSIONS-1:0] load_configure_o,
  output logic [NUM_SESSIONS-1:0] connect_o,
  output logic [NUM_SESSIONS-1:0] disconnect_o,
  output logic [NUM_SESSIONS-1:0] ignore_o,
  output logic [NUM_SESSIONS-1:0] session_up_o
);

  localparam int N     = NUM_SESSIONS;
  localparam int TMR_W = $clog2(HB_INTERVAL + RX_GRACE + RESP_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TX_LIM  = TMR_W'(HB_INTERVAL);
  localparam logic [TMR_W-1:0] RX_LIM  = TMR_W'(HB_INTERVAL + RX_GRACE);
  localparam logic [TMR_W-1:0] RSP_LIM = TMR_W'(RESP_TIMEOUT);

  rx_msg_t          rx_msg;
  logic [N-1:0]     tx_req, gnt;
  logic [SEQ_W-1:0] sess_seq  [N];
  logic [2:0]       sess_type [N];
  logic [SID_W-1:0] gnt_sid, sid_q, sid_d;
  logic             req_q, req_d, launch, ack_hit;
  logic [2:0]       type_q, type_d;
  logic [SEQ_W-1:0] oseq_q, oseq_d;

  assign rx_msg.msg_type = rx_msg_type_i;
  assign rx_msg.seq_ok   = rx_seq_ok_i;
  assign ack_hit         = req_q & msg_ack_i;

  fix_rr_arbiter #(.N(N)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (tx_req),
    .launch_i (launch),
    .ack_i    (ack_hit),
    .gnt_o    (gnt)
  );

  always_comb begin
    gnt_sid = '0;
    for (int k = 0; k < N; k++) if (gnt[k]) gnt_sid = SID_W'(k);
  end

  // A granted session that leaves TX without an ack (link drop) withdraws its request.
  always_comb begin
    req_d  = req_q;
    sid_d  = sid_q;
    type_d = type_q;
    oseq_d = oseq_q;
    launch = 1'b0;
    if (req_q) begin
      if (msg_ack_i || !tx_req[sid_q]) req_d = 1'b0;
    end else if (|tx_req) begin
      launch = 1'b1;
      req_d  = 1'b1;
      sid_d  = gnt_sid;
      type_d = sess_type[gnt_sid];
      oseq_d = sess_seq[gnt_sid];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= 1'b0;
      sid_q  <= '0;
      type_q <= '0;
      oseq_q <= '0;
    end else begin
      req_q  <= req_d;
      sid_q  <= sid_d;
      type_q <= type_d;
      oseq_q <= oseq_d;
    end
  end

  assign msg_req_o     = req_q;
  assign msg_session_o = sid_q;
  assign msg_type_o    = type_q;
  assign msg_seq_o     = oseq_q;

  for (genvar i = 0; i < N; i++) begin : g_sess
    sess_state_e      state_q, state_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [2:0]       tx_type_q, tx_type_d;
    logic             reply_q, reply_d;
    logic [TMR_W-1:0] tx_idle_q, tx_idle_d, rx_idle_q, rx_idle_d, resp_q, resp_d;
    logic             load_q, load_d, conn_q, conn_d, disc_q, disc_d, ign_q, ign_d;
    logic             own_rx, own_ack, timeout, go;

    assign own_rx  = rx_valid_i && (rx_session_i == SID_W'(i));
    assign own_ack = ack_hit && (sid_q == SID_W'(i));
    assign timeout = resp_q >= RSP_LIM;

    always_comb begin
      state_d   = state_q;
      seq_d     = seq_q;
      tx_type_d = tx_type_q;
      reply_d   = reply_q;
      load_d    = 1'b0;
      conn_d    = 1'b0;
      go        = 1'b0;
      ign_d     = own_rx && (state_q inside {S_IDLE, S_CONFIGURED, S_CONNECTING, S_TX});
      tx_idle_d = own_ack ? '0 : (tx_idle_q < TX_LIM ? tx_idle_q + TMR_W'(1) : tx_idle_q);
      rx_idle_d = own_rx  ? '0 : (rx_idle_q < RX_LIM ? rx_idle_q + TMR_W'(1) : rx_idle_q);
      unique case (state_q)
        S_IDLE:       if (configure_i[i]) begin state_d = S_CONFIGURED; load_d = 1'b1; end
        S_CONFIGURED: if (start_i[i]) begin state_d = S_CONNECTING; conn_d = 1'b1; end
        S_CONNECTING: if (connected_i[i]) begin
          seq_d     = SEQ_W'(1);
          tx_type_d = MSG_LOGON;
          state_d   = S_TX;
        end
        S_TX: if (own_ack) begin
          seq_d = seq_q + SEQ_W'(1);
          case (tx_type_q)
            MSG_LOGON:   state_d = S_LOGON_WAIT;
            MSG_TESTREQ: state_d = S_TESTREQ_WAIT;
            MSG_LOGOUT:  state_d = reply_q ? S_DISCONNECT : S_LOGOUT_WAIT;
            default:     state_d = S_ACTIVE;
          endcase
        end
        S_LOGON_WAIT: begin
          if (own_rx) state_d = (rx_msg.msg_type == MSG_LOGON && rx_msg.seq_ok) ? S_ACTIVE : S_DISCONNECT;
          else if (timeout) state_d = S_DISCONNECT;
        end
        S_ACTIVE: begin
          go = 1'b1;
          if (own_rx && !rx_msg.seq_ok)                   begin tx_type_d = MSG_LOGOUT; reply_d = 1'b0; end
          else if (own_rx && rx_msg.msg_type == MSG_LOGOUT) begin tx_type_d = MSG_LOGOUT; reply_d = 1'b1; end
          else if (own_rx && rx_msg.msg_type == MSG_TESTREQ) tx_type_d = MSG_HEARTBEAT;
          else if (end_session_i[i])                      begin tx_type_d = MSG_LOGOUT; reply_d = 1'b0; end
          else if (rx_idle_q >= RX_LIM)                   tx_type_d = MSG_TESTREQ;
          else if (tx_idle_q >= TX_LIM)                   tx_type_d = MSG_HEARTBEAT;
          else if (send_app_i[i])                         tx_type_d = MSG_BUSINESS;
          else                                            go = 1'b0;
          if (go) state_d = S_TX;
        end
        S_TESTREQ_WAIT: begin
          if (own_rx && rx_msg.seq_ok) state_d = S_ACTIVE;
          else if (timeout) begin
            tx_type_d = MSG_LOGOUT;
            reply_d   = 1'b1;
            state_d   = S_TX;
          end
        end
        S_LOGOUT_WAIT: if ((own_rx && rx_msg.msg_type == MSG_LOGOUT) || timeout) state_d = S_DISCONNECT;
        S_DISCONNECT:  state_d = S_IDLE;
        default:       state_d = S_IDLE;
      endcase
      if (!connected_i[i] && is_linked(state_q)) state_d = S_DISCONNECT;
      disc_d = (state_d == S_DISCONNECT) && (state_q != S_DISCONNECT);
      resp_d = (state_d != state_q && is_wait(state_d)) ? '0 :
               (resp_q < RSP_LIM ? resp_q + TMR_W'(1) : resp_q);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= S_IDLE;
        seq_q     <= SEQ_W'(1);
        tx_type_q <= '0;
        reply_q   <= 1'b0;
        tx_idle_q <= '0;
        rx_idle_q <= '0;
        resp_q    <= '0;
        load_q    <= 1'b0;
        conn_q    <= 1'b0;
        disc_q    <= 1'b0;
        ign_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        seq_q     <= seq_d;
        tx_type_q <= tx_type_d;
        reply_q   <= reply_d;
        tx_idle_q <= tx_idle_d;
        rx_idle_q <= rx_idle_d;
        resp_q    <= resp_d;
        load_q    <= load_d;
        conn_q    <= conn_d;
        disc_q    <= disc_d;
        ign_q     <= ign_d;
      end
    end

    assign tx_req[i]           = (state_q == S_TX);
    assign sess_seq[i]         = seq_q;
    assign sess_type[i]        = tx_type_q;
    assign load_configure_o[i] = load_q;
    assign connect_o[i]        = conn_q;
    assign disconnect_o[i]     = disc_q;
    assign ignore_o[i]         = ign_q;
    assign session_up_o[i]     = (state_q == S_ACTIVE) || (state_q == S_TESTREQ_WAIT);
  end

endmodule

// File: tb/tb_fix_multi_session_controller.sv
// Directed bench for the multi-session FIX controller with short timers
// (HB_INTERVAL=20, RX_GRACE=10, RESP_TIMEOUT=40).
module tb_fix_multi_session_controller;

  localparam logic [2:0] T_LOGON = 3'b001, T_HB = 3'b010, T_TR = 3'b011, T_LOGOUT = 3'b100, T_BUS = 3'b111;

  logic        clk;
  logic        rst;
  logic [3:0]  configure_i, start_i, end_session_i, send_app_i, connected_i;
  logic        rx_valid_i, rx_seq_ok_i, msg_ack_i;
  logic [1:0]  rx_session_i;
  logic [2:0]  rx_msg_type_i;
  logic        msg_req_o;
  logic [1:0]  msg_session_o;
  logic [2:0]  msg_type_o;
  logic [15:0] msg_seq_o;
  logic [3:0]  load_configure_o, connect_o, disconnect_o, ignore_o, session_up_o;

  int vec  = 0;
  int errs = 0;

  fix_multi_session_controller #(
    .NUM_SESSIONS(4), .SEQ_W(16), .HB_INTERVAL(20), .RX_GRACE(10), .RESP_TIMEOUT(40)
  ) dut (
    .clk(clk), .rst(rst), .configure_i(configure_i), .start_i(start_i),
    .end_session_i(end_session_i), .send_app_i(send_app_i), .connected_i(connected_i),
    .rx_valid_i(rx_valid_i), .rx_session_i(rx_session_i), .rx_msg_type_i(rx_msg_type_i),
    .rx_seq_ok_i(rx_seq_ok_i), .msg_ack_i(msg_ack_i), .msg_req_o(msg_req_o),
    .msg_session_o(msg_session_o), .msg_type_o(msg_type_o), .msg_seq_o(msg_seq_o),
    .load_configure_o(load_configure_o), .connect_o(connect_o), .disconnect_o(disconnect_o),
    .ignore_o(ignore_o), .session_up_o(session_up_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (msg_req_o === 1'b1) ok = 1'b1;
      else tick;
    end
  endtask

  task automatic send_rx(input int s, input logic [2:0] t, input logic sok);
    rx_valid_i = 1'b1; rx_session_i = 2'(s); rx_msg_type_i = t; rx_seq_ok_i = sok;
    tick;
    rx_valid_i = 1'b0;
  endtask

  // Takes session s from IDLE to ACTIVE; the ack edge and the RX LOGON edge are consecutive.
  task automatic bring_up(input int s, output bit ok);
    configure_i[s] = 1'b1; tick; configure_i[s] = 1'b0;
    start_i[s] = 1'b1; tick; start_i[s] = 1'b0;
    tick;
    wait_req(ok);
    msg_ack_i = 1'b1; tick; msg_ack_i = 1'b0;
    send_rx(s, T_LOGON, 1'b1);
  endtask

  task automatic test_reset;
    do_reset;
    vec++; if (msg_req_o !== 1'b0) begin errs++; $display("FAIL reset_req: got %b want 0", msg_req_o); end
    vec++; if (msg_session_o !== 2'd0 || msg_type_o !== 3'd0 || msg_seq_o !== 16'd0) begin errs++;
      $display("FAIL reset_msg: got sid=%0d type=%0h seq=%0d want 0/0/0", msg_session_o, msg_type_o, msg_seq_o); end
    vec++; if (session_up_o !== 4'h0) begin errs++; $display("FAIL reset_up: got %b want 0000", session_up_o); end
    vec++; if (load_configure_o !== 4'h0 || connect_o !== 4'h0) begin errs++;
      $display("FAIL reset_load_conn: got %b/%b want 0000/0000", load_configure_o, connect_o); end
    vec++; if (disconnect_o !== 4'h0 || ignore_o !== 4'h0) begin errs++;
      $display("FAIL reset_disc_ign: got %b/%b want 0000/0000", disconnect_o, ignore_o); end
  endtask

  task automatic test_full_cycle;
    connected_i = 4'hf;
    configure_i[0] = 1'b1; tick; configure_i[0] = 1'b0;
    vec++; if (load_configure_o !== 4'b0001) begin errs++; $display("FAIL fc_load: got %b want 0001", load_configure_o); end
    start_i[0] = 1'b1; tick; start_i[0] = 1'b0;
    vec++; if (connect_o !== 4'b0001 || load_configure_o !== 4'b0000) begin errs++;
      $display("FAIL fc_connect: got conn=%b load=%b want 0001/0000", connect_o, load_configure_o); end
    tick;
    vec++; if (msg_req_o !== 1'b0) begin errs++; $display("FAIL fc_tx_first_cycle: got req=%b want 0", msg_req_o); end
    tick;
    vec++; if (msg_req_o !== 1'b1 || msg_session_o !== 2'd0 || msg_type_o !== T_LOGON || msg_seq_o !== 16'd1) begin errs++;
      $display("FAIL fc_logon_req: got req=%b sid=%0d type=%0h seq=%0d want 1/0/1/1", msg_req_o, msg_session_o, msg_type_o, msg_seq_o); end
    msg_ack_i = 1'b1; tick; msg_ack_i = 1'b0;
    vec++; if (msg_req_o !== 1'b0 || session_up_o !== 4'b0000) begin errs++;
      $display("FAIL fc_logon_wait: got req=%b up=%b want 0/0000", msg_req_o, session_up_o); end
    send_rx(0, T_LOGON, 1'b1);
    vec++; if (session_up_o !== 4'b0001) begin errs++; $display("FAIL fc_up: got %b want 0001", session_up_o); end
    end_session_i[0] = 1'b1; tick; end_session_i[0] = 1'b0;
    tick;
    vec++; if (msg_req_o !== 1'b1 || msg_type_o !== T_LOGOUT || msg_seq_o !== 16'd2) begin errs++;
      $display("FAIL fc_logout_req: got req=%b type=%0h seq=%0d want 1/4/2", msg_req_o, msg_type_o, msg_seq_o); end
    msg_ack_i = 1'b1; tick; msg_ack_i = 1'b0;
    vec++; if (msg_req_o !== 1'b0 || session_up_o !== 4'b0000) begin errs++;
      $display("FAIL fc_logout_wait: got req=%b up=%b want 0/0000", msg_req_o, session_up_o); end
    send_rx(0, T_LOGOUT, 1'b1);
    vec++; if (disconnect_o !== 4'b0001) begin errs++; $display("FAIL fc_disc: got %b want 0001", disconnect_o); end
    tick;
    vec++; if (disconnect_o !== 4'b0000) begin errs++; $display("FAIL fc_disc_width: got %b want 0000", disconnect_o); end
  endtask

  task automatic test_logon_timeout;
    bit ok;
    int first, cnt;
    configure_i[1] = 1'b1; tick; configure_i[1] = 1'b0;
    start_i[1] = 1'b1; tick; start_i[1] = 1'b0;
    tick;
    wait_req(ok);
    vec++; if (!ok || msg_session_o !== 2'd1) begin errs++;
      $display("FAIL lt_req: got ok=%b sid=%0d want 1/1", ok, msg_session_o); end
    msg_ack_i = 1'b1; tick; msg_ack_i = 1'b0;
    first = 0; cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      tick;
      if (disconnect_o[1] === 1'b1) begin
        if (first == 0) first = k;
        cnt++;
      end
    end
    vec++; if (first != 41) begin errs++; $display("FAIL lt_disc_cycle: got %0d want 41", first); end
    vec++; if (cnt != 1) begin errs++; $display("FAIL lt_disc_pulses: got %0d want 1", cnt); end
  endtask

  // Cycle k counts edges after the logon ack (k=0); k=1 is the RX LOGON edge.
  task automatic test_heartbeat_testreq;
    bit ok;
    int k, first;
    bring_up(2, ok);
    vec++; if (!ok) begin errs++; $display("FAIL hb_bringup: got ok=0 want 1"); end
    k = 1; first = 0;
    while (first == 0 && k < 40) begin tick; k++; if (msg_req_o === 1'b1) first = k; end
    vec++; if (first != 22 || msg_session_o !== 2'd2 || msg_type_o !== T_HB || msg_seq_o !== 16'd2) begin errs++;
      $display("FAIL hb_req: got cyc=%0d sid=%0d type=%0h seq=%0d want 22/2/2/2", first, msg_session_o, msg_type_o, msg_seq_o); end
    msg_ack_i = 1'b1; tick; k++; msg_ack_i = 1'b0;
    first = 0;
    while (first == 0 && k < 60) begin tick; k++; if (msg_req_o === 1'b1) first = k; end
    vec++; if (first != 33 || msg_type_o !== T_TR || msg_seq_o !== 16'd3) begin errs++;
      $display("FAIL tr_req: got cyc=%0d type=%0h seq=%0d want 33/3/3", first, msg_type_o, msg_seq_o); end
    msg_ack_i = 1'b1; tick; k++; msg_ack_i = 1'b0;
    first = 0;
    while (first == 0 && k < 120) begin tick; k++; if (msg_req_o === 1'b1) first = k; end
    vec++; if (first != 76 || msg_type_o !== T_LOGOUT || msg_seq_o !== 16'd4) begin errs++;
      $display("FAIL tr_timeout_logout: got cyc=%0d type=%0h seq=%0d want 76/4/4", first, msg_type_o, msg_seq_o); end
    msg_ack_i = 1'b1; tick; msg_ack_i = 1'b0;
    vec++; if (disconnect_o !== 4'b0100) begin errs++; $display("FAIL tr_disc: got %b want 0100", disconnect_o); end
  endtask

  task automatic test_round_robin;
    bit ok;
    do_reset;
    configure_i = 4'hf; tick; configure_i = 4'h0;
    start_i = 4'hf; tick; start_i = 4'h0;
    tick;
    for (int j = 0; j < 4; j++) begin
      wait_req(ok);
      vec++; if (!ok || msg_session_o !== 2'(j) || msg_type_o !== T_LOGON || msg_seq_o !== 16'd1) begin errs++;
        $display("FAIL rr_logon%0d: got ok=%b sid=%0d type=%0h seq=%0d want 1/%0d/1/1", j, ok, msg_session_o, msg_type_o, msg_seq_o, j); end
      msg_ack_i = 1'b1; tick; msg_ack_i = 1'b0;
      vec++; if (msg_req_o !== 1'b0) begin errs++; $display("FAIL rr_gap%0d: got req=%b want 0", j, msg_req_o); end
    end
    for (int j = 0; j < 4; j++) send_rx(j, T_LOGON, 1'b1);
    vec++; if (session_up_o !== 4'hf) begin errs++; $display("FAIL rr_up: got %b want 1111", session_up_o); end
    send_app_i = 4'hf; tick; send_app_i = 4'h0;
    for (int j = 0; j < 4; j++) begin
      wait_req(ok);
      vec++; if (!ok || msg_session_o !== 2'(j) || msg_type_o !== T_BUS || msg_seq_o !== 16'd2) begin errs++;
        $display("FAIL rr_bus%0d: got ok=%b sid=%0d type=%0h seq=%0d want 1/%0d/7/2", j, ok, msg_session_o, msg_type_o, msg_seq_o, j); end
      msg_ack_i = 1'b1; tick; msg_ack_i = 1'b0;
    end
    vec++; if (session_up_o !== 4'hf) begin errs++; $display("FAIL rr_up_after: got %b want 1111", session_up_o); end
  endtask

  task automatic test_ignore;
    bit ok;
    do_reset;
    bring_up(2, ok);
    send_app_i[2] = 1'b1; tick; send_app_i[2] = 1'b0;
    tick;
    vec++; if (!ok || msg_req_o !== 1'b1 || msg_session_o !== 2'd2 || msg_type_o !== T_BUS || msg_seq_o !== 16'd2) begin errs++;
      $display("FAIL ig_req: got ok=%b req=%b sid=%0d type=%0h seq=%0d want 1/1/2/7/2", ok, msg_req_o, msg_session_o, msg_type_o, msg_seq_o); end
    send_rx(2, T_HB, 1'b1);
    vec++; if (ignore_o !== 4'b0100) begin errs++; $display("FAIL ig_pulse: got %b want 0100", ignore_o); end
    vec++; if (msg_req_o !== 1'b1 || msg_type_o !== T_BUS || msg_seq_o !== 16'd2) begin errs++;
      $display("FAIL ig_req_held: got req=%b type=%0h seq=%0d want 1/7/2", msg_req_o, msg_type_o, msg_seq_o); end
    tick;
    vec++; if (ignore_o !== 4'b0000) begin errs++; $display("FAIL ig_pulse_width: got %b want 0000", ignore_o); end
    msg_ack_i = 1'b1; tick; msg_ack_i = 1'b0;
  endtask

  task automatic test_seq_error;
    send_app_i[2] = 1'b1;
    send_rx(2, T_HB, 1'b0);
    send_app_i[2] = 1'b0;
    tick;
    vec++; if (msg_req_o !== 1'b1 || msg_type_o !== T_LOGOUT || msg_seq_o !== 16'd3) begin errs++;
      $display("FAIL se_logout: got req=%b type=%0h seq=%0d want 1/4/3", msg_req_o, msg_type_o, msg_seq_o); end
  endtask

  task automatic test_reset_mid_request;
    rst = 1'b1; tick;
    vec++; if (msg_req_o !== 1'b0) begin errs++; $display("FAIL rm_req_drop: got %b want 0", msg_req_o); end
    rst = 1'b0;
    msg_ack_i = 1'b1; tick; msg_ack_i = 1'b0;
    vec++; if (msg_req_o !== 1'b0 || session_up_o !== 4'h0 || disconnect_o !== 4'h0) begin errs++;
      $display("FAIL rm_late_ack: got req=%b up=%b disc=%b want 0/0000/0000", msg_req_o, session_up_o, disconnect_o); end
    start_i[2] = 1'b1; tick; start_i[2] = 1'b0;
    vec++; if (connect_o !== 4'h0) begin errs++; $display("FAIL rm_idle_start: got %b want 0000", connect_o); end
    configure_i[2] = 1'b1; tick; configure_i[2] = 1'b0;
    vec++; if (load_configure_o !== 4'b0100) begin errs++; $display("FAIL rm_idle_cfg: got %b want 0100", load_configure_o); end
  endtask

  initial begin
    rst = 1'b1;
    configure_i = '0; start_i = '0; end_session_i = '0; send_app_i = '0; connected_i = '0;
    rx_valid_i = 1'b0; rx_session_i = '0; rx_msg_type_i = '0; rx_seq_ok_i = 1'b0; msg_ack_i = 1'b0;
    test_reset;
    test_full_cycle;
    test_logon_timeout;
    test_heartbeat_testreq;
    test_round_robin;
    test_ignore;
    test_seq_error;
    test_reset_mid_request;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
